// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: NOP encoding, default reset PC, and the
// next-PC select encoding also used by the hazard unit.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_JUMP   = 2'd1,
        NPC_JR     = 2'd2,
        NPC_BRANCH = 2'd3
    } npc_sel_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold (stall) and clear (bubble) controls;
// clear wins over hold so a redirect always squashes the slot.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              hold,
    input  logic              clear,
    input  logic [DATA_W-1:0] fetch_instr,
    input  logic [DATA_W-1:0] fetch_pc4,
    input  logic              fetch_valid,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] pc4,
    output logic              valid
);

    always_ff @(posedge Clk) begin
        if (Rst || clear) begin
            instr <= DATA_W'(NOP_INSTR);
            pc4   <= '0;
            valid <= 1'b0;
        end else if (!hold) begin
            instr <= fetch_instr;
            pc4   <= fetch_pc4;
            valid <= fetch_valid;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select with fixed redirect
// priority, target alignment check, fetch counter and the IF/ID register.
module if_fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_target,
    input  logic        JR,
    input  logic [31:0] JR_target,
    input  logic        Jump,
    input  logic [31:0] Jump_target,
    input  logic [31:0] Imem_data,
    output logic [31:0] Imem_addr,
    output logic [31:0] PCAdder_out_IF,
    output logic [31:0] Instruction_ID,
    output logic [31:0] PCAdder_out_ID,
    output logic        Valid_ID,
    output logic [31:0] Fetch_count,
    output logic        Misalign_err
);

    logic [31:0] pc_p0;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic        redirect;
    npc_sel_e    npc_sel;

    assign pc_plus4       = pc_p0 + 32'd4;
    assign Imem_addr      = pc_p0;
    assign PCAdder_out_IF = pc_plus4;

    // EX-stage requests are older than ID-stage ones, so they win.
    always_comb begin
        npc_sel = NPC_SEQ;
        if (Branch_taken)  npc_sel = NPC_BRANCH;
        else if (JR)       npc_sel = NPC_JR;
        else if (Jump)     npc_sel = NPC_JUMP;
    end

    always_comb begin
        redirect_target = pc_plus4;
        case (npc_sel)
            NPC_BRANCH: redirect_target = Branch_target;
            NPC_JR:     redirect_target = JR_target;
            NPC_JUMP:   redirect_target = Jump_target;
            default:    redirect_target = pc_plus4;
        endcase
    end

    assign redirect = (npc_sel != NPC_SEQ);

    // ---- IF -> PC / counters ----
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_p0        <= RESET_PC;
            Fetch_count  <= '0;
            Misalign_err <= 1'b0;
        end else if (redirect) begin
            pc_p0 <= word_align(redirect_target);
            if (redirect_target[1:0] != 2'b00)
                Misalign_err <= 1'b1;
        end else if (!Stall) begin
            pc_p0       <= pc_plus4;
            Fetch_count <= Fetch_count + 32'd1;
        end
    end

    // ---- IF -> ID ----
    if_id_reg #(
        .DATA_W(32)
    ) u_if_id (
        .Clk         (Clk),
        .Rst         (Rst),
        .hold        (Stall),
        .clear       (redirect),
        .fetch_instr (Imem_data),
        .fetch_pc4   (pc_plus4),
        .fetch_valid (1'b1),
        .instr       (Instruction_ID),
        .pc4         (PCAdder_out_ID),
        .valid       (Valid_ID)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed steps from the test plan, then random
// stimulus, all checked against an architectural model of the fetch stage.
module tb_if_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst, Stall, Branch_taken, JR, Jump;
    logic [31:0] Branch_target, JR_target, Jump_target, Imem_data;
    logic [31:0] Imem_addr, PCAdder_out_IF, Instruction_ID, PCAdder_out_ID, Fetch_count;
    logic        Valid_ID, Misalign_err;

    int tests = 0;
    int fails = 0;
    bit scramble = 1'b0;

    // model state
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_mis;

    if_fetch_stage dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall),
        .Branch_taken(Branch_taken), .Branch_target(Branch_target),
        .JR(JR), .JR_target(JR_target), .Jump(Jump), .Jump_target(Jump_target),
        .Imem_data(Imem_data), .Imem_addr(Imem_addr), .PCAdder_out_IF(PCAdder_out_IF),
        .Instruction_ID(Instruction_ID), .PCAdder_out_ID(PCAdder_out_ID),
        .Valid_ID(Valid_ID), .Fetch_count(Fetch_count), .Misalign_err(Misalign_err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input bit scr);
        return scr ? (a ^ 32'h5A5A_C3C3) : a;
    endfunction

    assign Imem_data = mem_word(Imem_addr, scramble);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_addr", Imem_addr, m_pc);
        chk("pc4_if", PCAdder_out_IF, m_pc + 32'd4);
        chk("instr_id", Instruction_ID, m_instr);
        chk("pc4_id", PCAdder_out_ID, m_pc4);
        chk("valid_id", {31'd0, Valid_ID}, {31'd0, m_valid});
        chk("fetch_count", Fetch_count, m_count);
        chk("misalign", {31'd0, Misalign_err}, {31'd0, m_mis});
    endtask

    // Drive one cycle of inputs, advance the model, clock, then compare.
    task automatic cycle(input bit rst, input bit stall,
                         input bit bt, input logic [31:0] btgt,
                         input bit jr, input logic [31:0] jrt,
                         input bit j,  input logic [31:0] jt);
        logic [31:0] tgt;
        Rst = rst; Stall = stall;
        Branch_taken = bt; Branch_target = btgt;
        JR = jr; JR_target = jrt; Jump = j; Jump_target = jt;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_count = 32'h0; m_mis = 1'b0;
        end else if (bt || jr || j) begin
            tgt = bt ? btgt : (jr ? jrt : jt);
            if (tgt % 4 != 0) m_mis = 1'b1;
            m_pc = tgt - (tgt % 4);
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!stall) begin
            m_instr = mem_word(m_pc, scramble);
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_count = m_count + 32'd1;
            m_pc    = m_pc + 32'd4;
        end
        @(posedge Clk);
        #1;
        check_all();
    endtask

    task automatic free_run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        Rst = 1'b1; Stall = 1'b0; Branch_taken = 1'b0; JR = 1'b0; Jump = 1'b0;
        Branch_target = '0; JR_target = '0; Jump_target = '0;

        // reset for two cycles
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_addr", Imem_addr, 32'h0);
        chk("rst_pc4", PCAdder_out_IF, 32'h4);
        chk("rst_valid", {31'd0, Valid_ID}, 32'd0);

        // free run: first valid entry
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("first_instr", Instruction_ID, 32'h0);
        chk("first_pc4", PCAdder_out_ID, 32'h4);
        chk("first_valid", {31'd0, Valid_ID}, 32'd1);
        free_run(1);
        chk("pc_at_8", Imem_addr, 32'h8);

        // stall two cycles at PC=8, then release
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        chk("stall_pc", Imem_addr, 32'h8);
        chk("stall_count", Fetch_count, 32'd2);
        chk("stall_instr", Instruction_ID, 32'h4);
        free_run(1);
        chk("release_pc", Imem_addr, 32'hC);
        chk("count3", Fetch_count, 32'd3);

        // branch overrides stall
        cycle(0, 1, 1, 32'h40, 0, 0, 0, 0);
        chk("br_pc", Imem_addr, 32'h40);
        chk("br_bubble", {31'd0, Valid_ID}, 32'd0);
        free_run(1);
        chk("br_instr", Instruction_ID, 32'h40);

        // simultaneous redirects; unselected misaligned targets ignored
        cycle(0, 0, 1, 32'h80, 0, 32'h43, 1, 32'h101);
        chk("sim_pc", Imem_addr, 32'h80);
        chk("sim_nomis", {31'd0, Misalign_err}, 32'd0);
        cycle(0, 0, 0, 0, 1, 32'h200, 1, 32'h100);
        chk("jr_over_jump", Imem_addr, 32'h200);

        // misaligned JR: sticky error
        cycle(0, 0, 0, 0, 1, 32'h43, 0, 0);
        chk("mis_pc", Imem_addr, 32'h40);
        chk("mis_set", {31'd0, Misalign_err}, 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 1, 32'h20);
        free_run(2);
        chk("mis_sticky", {31'd0, Misalign_err}, 32'd1);

        // PC wraps modulo 2^32
        cycle(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        chk("wrap_pc4", PCAdder_out_IF, 32'h0);
        free_run(2);
        chk("wrap_pc", Imem_addr, 32'h4);

        // reset mid-run beats stall and jump
        cycle(0, 0, 0, 0, 0, 0, 1, 32'h20);
        cycle(1, 1, 0, 0, 0, 0, 1, 32'h300);
        chk("mid_rst_pc", Imem_addr, 32'h0);
        chk("mid_rst_count", Fetch_count, 32'd0);
        chk("mid_rst_mis", {31'd0, Misalign_err}, 32'd0);

        // random traffic with a scrambled instruction memory
        scramble = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] bt_t, jr_t, j_t;
            bt_t = $urandom; jr_t = $urandom; j_t = $urandom;
            if ($urandom_range(3) != 0) bt_t[1:0] = 2'b00;
            if ($urandom_range(3) != 0) jr_t[1:0] = 2'b00;
            if ($urandom_range(3) != 0) j_t[1:0]  = 2'b00;
            cycle($urandom_range(63) == 0, $urandom_range(3) == 0,
                  $urandom_range(7) == 0, bt_t,
                  $urandom_range(7) == 0, jr_t,
                  $urandom_range(7) == 0, j_t);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the program counter, computes PC+4, selects the next PC from the branch/jump/JR redirect requests, and drives the external instruction memory address. Latches fetched instructions into the IF/ID pipeline register that feeds decode. Honours stall requests from the hazard unit and squashes the IF/ID slot on redirects. Its PC+4 output is the value the top-level bench traces each clock.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- Clk  in  1  pipeline clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- Stall  in  1  hazard unit: hold PC and IF/ID contents
- Branch_taken  in  1  taken branch resolved in EX
- Branch_target  in  32  branch target address
- JR  in  1  jump-register resolved in EX
- JR_target  in  32  register value for JR
- Jump  in  1  J/JAL decoded in ID
- Jump_target  in  32  jump target address
- Imem_data  in  32  instruction word at Imem_addr (combinational read)
- Imem_addr  out  32  current PC, word-aligned
- PCAdder_out_IF  out  32  PC + 4 (combinational)
- Instruction_ID  out  32  IF/ID instruction
- PCAdder_out_ID  out  32  IF/ID PC+4
- Valid_ID  out  1  IF/ID holds a real instruction (0 = bubble)
- Fetch_count  out  32  instructions latched valid into IF/ID since reset
- Misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0

## Operation
- Redirect priority, fixed: Branch_taken > JR > Jump > sequential (PC+4). EX-stage requests are older than ID-stage requests.
- Any redirect overrides Stall. PC loads the target, and IF/ID loads a bubble: Instruction_ID=NOP (32'h0), PCAdder_out_ID=0, Valid_ID=0.
- No branch delay slot. The instruction fetched in the redirect cycle is always squashed.
- Stall without redirect: PC, IF/ID, and Fetch_count hold.
- Neither stall nor redirect: PC <= PC+4. IF/ID <= {Imem_data, PC+4, valid=1}. Fetch_count increments.
- Target alignment: bits [1:0] of the selected redirect target are forced to 00 before loading PC. If either bit was 1, Misalign_err sets and stays set until Rst.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. Fetch_count wraps from 32'hFFFF_FFFF to 0.
- Only the selected target is checked for alignment. Unselected targets are ignored.

## Timing
- Reset values: PC=RESET_PC, so Imem_addr=RESET_PC and PCAdder_out_IF=RESET_PC+4. Instruction_ID=0, PCAdder_out_ID=0, Valid_ID=0, Fetch_count=0, Misalign_err=0.
- Rst takes priority over Stall, redirects, and everything else, including when asserted mid-run.
- Fetch latency: the instruction at PC appears on Instruction_ID one rising edge after the cycle in which it is addressed, provided there is no stall or redirect.
- First valid IF/ID entry: on the first edge with Rst=0, Stall=0, and no redirect.
- Redirect latency: target on Imem_addr in the cycle after the request. Its instruction is valid in IF/ID one edge later.
- Imem_addr and PCAdder_out_IF are combinational from the PC register. All other outputs are registered.

## Structure
- Shared package pipeline_pkg holds:
  - NOP_INSTR constant (32'h0)
  - default RESET_PC
  - the 2-bit next-PC select encoding (SEQ, JUMP, JR, BRANCH), also used by the hazard unit
- One sub-module: if_id_reg, the IF/ID pipeline register with hold (stall) and clear (bubble) controls. It is reused as a pattern for ID/EX.
- The next-PC mux, alignment check, and counters stay inline.

## Test plan
- Reset and free run: Rst for 2 cycles, imem word = address. After release, Imem_addr reads 0,4,8,… and Instruction_ID=0x0 with PCAdder_out_ID=0x4 and Valid_ID=1 after the first edge. Fetch_count=3 after 3 free edges.
- Stall: assert Stall for 2 cycles at PC=0x8. PC stays 0x8, IF/ID and Fetch_count unchanged. On release, PC=0xC next edge.
- Redirect over stall: Branch_taken=1, Branch_target=0x40, Stall=1. Next cycle PC=0x40, Valid_ID=0, Instruction_ID=0. One edge later Instruction_ID=0x40.
- Simultaneous redirects: Branch_target=0x80 together with Jump_target=0x100. PC=0x80.
- Misaligned JR: JR_target=0x43 gives PC=0x40 and Misalign_err=1. Misalign_err stays 1 through later aligned redirects until Rst.
- Reset mid-run: at PC=0x20 with Stall=1 and Jump=1, assert Rst. Next cycle PC=0, Valid_ID=0, Fetch_count=0, Misalign_err=0.
